pc_stack: RTL and testbench

//   Next-generation program counter for the Hmmm core: parametrised width, absolute and
//   PC-relative jumps, and a hardware return-address stack for call/return.

---
 rtl/pc_stack_if.sv | 39 +++
 rtl/pc_stack.sv | 124 ++++++++++++
 tb/tb_pc_stack.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
// pc_stack_if -- control/status bundle between the control FSM and pc_stack.
//   master : control FSM side (drives strobes, observes PC and stack status)
//   slave  : pc_stack side (receives strobes, reports PC and stack status)
// Signals
//   pc_out, increment, jump, jump_rel, call, ret : one-cycle control strobes
//   pc_value                                     : current PC
//   depth                                        : valid return-stack entries
//   stack_full, stack_empty                      : depth == DEPTH / depth == 0
//   overflow, underflow                          : sticky stack error flags
// The shared data bus is tristate and stays a plain inout port on pc_stack.
interface pc_stack_if #(
   parameter int N     = 8,
   parameter int DEPTH = 4
);
   localparam int DW = $clog2(DEPTH + 1);

   logic          pc_out;
   logic          increment;
   logic          jump;
   logic          jump_rel;
   logic          call;
   logic          ret;
   logic [N-1:0]  pc_value;
   logic [DW-1:0] depth;
   logic          stack_full;
   logic          stack_empty;
   logic          overflow;
   logic          underflow;

   modport master (
      output pc_out, increment, jump, jump_rel, call, ret,
      input  pc_value, depth, stack_full, stack_empty, overflow, underflow
   );

   modport slave (
      input  pc_out, increment, jump, jump_rel, call, ret,
      output pc_value, depth, stack_full, stack_empty, overflow, underflow
   );
endinterface

// File: rtl/pc_stack.sv
// pc_stack -- program counter with absolute/relative jumps and a hardware
// return-address stack for call/return.
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset (PC=RESET_ADDR, stack emptied,
//           error flags cleared)
//   ctl   : pc_stack_if.slave control strobes and status outputs
//   data  : shared N-bit tristate bus; carries PC while pc_out=1, else high-Z;
//           jump/call/jump_rel targets are sampled from it at the clock edge
// One action per cycle, priority ret > call > jump > jump_rel > increment.
module pc_stack #(
   parameter int N          = 8,
   parameter int DEPTH      = 4,
   parameter int RESET_ADDR = 0
) (
   input  logic         clk,
   input  logic         rst,
   pc_stack_if.slave    ctl,
   inout  wire  [N-1:0] data
);
   localparam int DW = $clog2(DEPTH + 1);
   // Only depth values below DEPTH ever address the stack, so the index
   // needs clog2(DEPTH) bits (one bit minimum for a single-entry stack).
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_INC,
      ACT_JUMP,
      ACT_REL,
      ACT_CALL,
      ACT_RET
   } action_e;

   action_e       act;
   logic [N-1:0]  pc_q, pc_d, pc_plus1;
   logic [DW-1:0] depth_q, depth_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          full, empty, push;
   logic [AW-1:0] push_idx, pop_idx;
   logic [N-1:0]  stack_mem [DEPTH];

   assign data = ctl.pc_out ? pc_q : {N{1'bz}};

   assign full     = (depth_q == DW'(DEPTH));
   assign empty    = (depth_q == '0);
   assign pc_plus1 = pc_q + N'(1);
   assign push_idx = AW'(depth_q);
   assign pop_idx  = AW'(depth_q - DW'(1));

   // Strobe decode: a single action per cycle in fixed priority order.
   always_comb begin
      act = ACT_HOLD;
      if (ctl.ret)            act = ACT_RET;
      else if (ctl.call)      act = ACT_CALL;
      else if (ctl.jump)      act = ACT_JUMP;
      else if (ctl.jump_rel)  act = ACT_REL;
      else if (ctl.increment) act = ACT_INC;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      pc_d    = pc_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      case (act)
         ACT_RET: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               pc_d    = stack_mem[pop_idx];
               depth_d = depth_q - DW'(1);
            end
         end
         ACT_CALL: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               push    = 1'b1;
               pc_d    = data;
               depth_d = depth_q + DW'(1);
            end
         end
         ACT_JUMP: pc_d = data;
         // Two's-complement offset: the N-bit sum wraps, so signed and
         // unsigned addition give the same result.
         ACT_REL:  pc_d = pc_q + data;
         ACT_INC:  pc_d = pc_plus1;
         default:  ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= N'(RESET_ADDR);
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // NOTE: the stack RAM is deliberately left out of reset; depth alone
   // decides which entries are valid, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (push) stack_mem[push_idx] <= pc_plus1;
   end

   assign ctl.pc_value    = pc_q;
   assign ctl.depth       = depth_q;
   assign ctl.stack_full  = full;
   assign ctl.stack_empty = empty;
   assign ctl.overflow    = ovf_q;
   assign ctl.underflow   = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack -- self-checking bench for pc_stack.
// Two instances share the control strobes: A (N=8, DEPTH=4) and
// B (N=12, DEPTH=8). Bus values are given as 32-bit numbers and truncated
// per instance, so -2 / -4 land on the top of each PC range.
// Each step pushes the model's expected post-edge state to a queue and pops
// it for comparison once the edge has happened.
module tb_pc_stack;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic pc_out = 1'b0, increment = 1'b0, jump = 1'b0;
   logic jump_rel = 1'b0, call = 1'b0, ret = 1'b0;
   logic        drv_en  = 1'b0;
   logic [31:0] drv_val = '0;

   wire [7:0]  data_a;
   wire [11:0] data_b;
   assign data_a = drv_en ? drv_val[7:0]  : 8'bz;
   assign data_b = drv_en ? drv_val[11:0] : 12'bz;

   pc_stack_if #(.N(8),  .DEPTH(4)) if_a ();
   pc_stack_if #(.N(12), .DEPTH(8)) if_b ();

   assign if_a.pc_out = pc_out;   assign if_b.pc_out = pc_out;
   assign if_a.increment = increment; assign if_b.increment = increment;
   assign if_a.jump = jump;       assign if_b.jump = jump;
   assign if_a.jump_rel = jump_rel; assign if_b.jump_rel = jump_rel;
   assign if_a.call = call;       assign if_b.call = call;
   assign if_a.ret = ret;         assign if_b.ret = ret;

   pc_stack #(.N(8), .DEPTH(4), .RESET_ADDR(0)) dut_a (
      .clk(clk), .rst(rst), .ctl(if_a.slave), .data(data_a));
   pc_stack #(.N(12), .DEPTH(8), .RESET_ADDR(0)) dut_b (
      .clk(clk), .rst(rst), .ctl(if_b.slave), .data(data_b));

   // Strobe vector layout {pc_out, increment, jump, jump_rel, call, ret}
   localparam logic [5:0] S_OUT = 6'b100000, S_INC = 6'b010000, S_JMP = 6'b001000;
   localparam logic [5:0] S_REL = 6'b000100, S_CALL = 6'b000010, S_RET = 6'b000001;

   typedef struct packed {
      logic [7:0][31:0] stk;
      logic [31:0]      pc;
      logic [31:0]      depth;
      logic             ovf;
      logic             unf;
   } model_t;

   model_t ma, mb;
   model_t exp_a[$], exp_b[$];
   int n_cmp = 0;
   int n_mis = 0;

   // Reference behaviour of one PC stack of width n and capacity dmax.
   function automatic model_t model_next(model_t m, int n, int dmax,
                                         logic [5:0] s, logic [31:0] val);
      logic [31:0] mask, d;
      mask = (32'h1 << n) - 32'h1;
      d    = s[5] ? m.pc : (val & mask);
      if (s[0]) begin
         if (m.depth == 0) m.unf = 1'b1;
         else begin
            m.depth = m.depth - 1;
            m.pc    = m.stk[m.depth[2:0]];
         end
      end else if (s[1]) begin
         if (m.depth == dmax) m.ovf = 1'b1;
         else begin
            m.stk[m.depth[2:0]] = (m.pc + 1) & mask;
            m.depth = m.depth + 1;
            m.pc    = d;
         end
      end else if (s[3]) m.pc = d;
      else if (s[2]) m.pc = (m.pc + d) & mask;
      else if (s[4]) m.pc = (m.pc + 1) & mask;
      return m;
   endfunction

   task automatic step(input logic [5:0] s, input logic [31:0] val);
      model_t ea, eb;
      @(negedge clk);
      {pc_out, increment, jump, jump_rel, call, ret} = s;
      drv_en  = !s[5];
      drv_val = val;
      #1;
      n_cmp++;
      if (s[5] ? (data_a !== ma.pc[7:0]) : (data_a !== val[7:0])) begin
         n_mis++;
         $display("FAIL bus_a: got %h want %h", data_a, s[5] ? ma.pc[7:0] : val[7:0]);
      end
      n_cmp++;
      if (s[5] ? (data_b !== mb.pc[11:0]) : (data_b !== val[11:0])) begin
         n_mis++;
         $display("FAIL bus_b: got %h want %h", data_b, s[5] ? mb.pc[11:0] : val[11:0]);
      end
      ma = model_next(ma, 8, 4, s, val);
      mb = model_next(mb, 12, 8, s, val);
      exp_a.push_back(ma);
      exp_b.push_back(mb);
      @(posedge clk);
      #1;
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      n_cmp++;
      if ({if_a.pc_value, if_a.depth, if_a.stack_full, if_a.stack_empty, if_a.overflow, if_a.underflow}
          !== {ea.pc[7:0], ea.depth[2:0], ea.depth == 32'd4, ea.depth == 32'd0, ea.ovf, ea.unf}) begin
         n_mis++;
         $display("FAIL state_a: got pc=%h dep=%0d full=%b empty=%b ovf=%b unf=%b want pc=%h dep=%0d ovf=%b unf=%b",
                  if_a.pc_value, if_a.depth, if_a.stack_full, if_a.stack_empty, if_a.overflow,
                  if_a.underflow, ea.pc[7:0], ea.depth, ea.ovf, ea.unf);
      end
      n_cmp++;
      if ({if_b.pc_value, if_b.depth, if_b.stack_full, if_b.stack_empty, if_b.overflow, if_b.underflow}
          !== {eb.pc[11:0], eb.depth[3:0], eb.depth == 32'd8, eb.depth == 32'd0, eb.ovf, eb.unf}) begin
         n_mis++;
         $display("FAIL state_b: got pc=%h dep=%0d full=%b empty=%b ovf=%b unf=%b want pc=%h dep=%0d ovf=%b unf=%b",
                  if_b.pc_value, if_b.depth, if_b.stack_full, if_b.stack_empty, if_b.overflow,
                  if_b.underflow, eb.pc[11:0], eb.depth, eb.ovf, eb.unf);
      end
      {pc_out, increment, jump, jump_rel, call, ret} = '0;
      drv_en = 1'b0;
   endtask

   // Asynchronous reset pulse between edges; outputs must clear before the next edge.
   task automatic pulse_reset(input string tag);
      {pc_out, increment, jump, jump_rel, call, ret} = '0;
      drv_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({if_a.pc_value, if_a.depth, if_a.stack_full, if_a.stack_empty, if_a.overflow, if_a.underflow}
          !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_mis++;
         $display("FAIL %s_rst_a: got pc=%h dep=%0d full=%b empty=%b ovf=%b unf=%b want pc=00 dep=0 empty=1",
                  tag, if_a.pc_value, if_a.depth, if_a.stack_full, if_a.stack_empty, if_a.overflow, if_a.underflow);
      end
      n_cmp++;
      if ({if_b.pc_value, if_b.depth, if_b.stack_full, if_b.stack_empty, if_b.overflow, if_b.underflow}
          !== {12'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_mis++;
         $display("FAIL %s_rst_b: got pc=%h dep=%0d full=%b empty=%b ovf=%b unf=%b want pc=000 dep=0 empty=1",
                  tag, if_b.pc_value, if_b.depth, if_b.stack_full, if_b.stack_empty, if_b.overflow, if_b.underflow);
      end
      ma = '0;
      mb = '0;
      exp_a.delete();
      exp_b.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic expect_a(input string name, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic expect_b(input string name, input logic [11:0] got, input logic [11:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic test_reset();
      pulse_reset("init");
   endtask

   task automatic test_async_reset();
      step(S_CALL, 32'h10);
      step(S_CALL, 32'h20);
      step(S_JMP, 32'h36);
      step(S_INC, 32'h0);
      expect_a("t1_pc_a", if_a.pc_value, 8'h37);
      expect_a("t1_depth_a", 8'(if_a.depth), 8'd2);
      pulse_reset("t1");
   endtask

   task automatic test_increment();
      step(S_JMP, 32'hFFFF_FFFE);
      step(S_INC | S_OUT, 32'h0);
      expect_a("t2_inc1_a", if_a.pc_value, 8'hFF);
      expect_b("t2_inc1_b", if_b.pc_value, 12'hFFF);
      step(S_INC, 32'h0);
      expect_a("t2_inc2_a", if_a.pc_value, 8'h00);
      expect_b("t2_inc2_b", if_b.pc_value, 12'h000);
      step(S_INC | S_OUT, 32'h0);
      expect_a("t2_inc3_a", if_a.pc_value, 8'h01);
      expect_b("t2_inc3_b", if_b.pc_value, 12'h001);
      step(S_OUT, 32'h0);
      step(6'b0, 32'h5A);
   endtask

   task automatic test_call_ret();
      pulse_reset("t3");
      step(S_JMP, 32'h10);
      step(S_CALL, 32'h80);
      expect_a("t3_call1_pc_a", if_a.pc_value, 8'h80);
      expect_a("t3_call1_dep_a", 8'(if_a.depth), 8'd1);
      step(S_CALL, 32'h90);
      expect_a("t3_call2_dep_a", 8'(if_a.depth), 8'd2);
      step(S_RET, 32'h0);
      expect_a("t3_ret1_a", if_a.pc_value, 8'h81);
      step(S_RET, 32'h0);
      expect_a("t3_ret2_a", if_a.pc_value, 8'h11);
      expect_b("t3_ret2_b", if_b.pc_value, 12'h011);
      expect_a("t3_empty_a", 8'(if_a.stack_empty), 8'd1);
   endtask

   task automatic test_stack_limits();
      pulse_reset("t4");
      step(S_JMP, 32'h40);
      for (int i = 0; i < 9; i++) begin
         step(S_CALL, 32'h50 + 32'(i));
         if (i == 4) begin
            expect_a("t4_ovf_pc_a", if_a.pc_value, 8'h53);
            expect_a("t4_ovf_flag_a", 8'(if_a.overflow), 8'd1);
            expect_a("t4_full_a", 8'(if_a.stack_full), 8'd1);
         end
      end
      expect_b("t4_ovf_pc_b", if_b.pc_value, 12'h057);
      expect_b("t4_full_b", 12'({if_b.stack_full, if_b.overflow}), 12'h003);
      for (int i = 0; i < 9; i++) begin
         step(S_RET, 32'h0);
         if (i == 3) expect_a("t4_unwind_a", if_a.pc_value, 8'h41);
         if (i == 4) begin
            expect_a("t4_unf_pc_a", if_a.pc_value, 8'h41);
            expect_a("t4_unf_flag_a", 8'(if_a.underflow), 8'd1);
         end
         if (i == 7) expect_b("t4_unwind_b", if_b.pc_value, 12'h041);
      end
      expect_b("t4_unf_flag_b", 12'(if_b.underflow), 12'h001);
   endtask

   task automatic test_jump_rel();
      step(S_JMP, 32'h05);
      step(S_REL, 32'hFFFF_FFFC);
      expect_a("t5_neg_a", if_a.pc_value, 8'h01);
      expect_b("t5_neg_b", if_b.pc_value, 12'h001);
      step(S_JMP, 32'hF0);
      step(S_REL, 32'h20);
      expect_a("t5_wrap_a", if_a.pc_value, 8'h10);
      expect_b("t5_pos_b", if_b.pc_value, 12'h110);
   endtask

   task automatic test_priority();
      pulse_reset("t6");
      step(S_CALL, 32'h30);
      step(S_RET | S_CALL | S_JMP | S_INC, 32'h77);
      expect_a("t6_ret_wins_a", if_a.pc_value, 8'h01);
      expect_a("t6_ret_dep_a", 8'(if_a.depth), 8'd0);
      step(S_JMP | S_INC, 32'h66);
      expect_a("t6_jump_wins_a", if_a.pc_value, 8'h66);
      step(S_JMP | S_OUT, 32'h0);
      expect_a("t6_jump_own_pc_a", if_a.pc_value, 8'h66);
      step(S_RET | S_CALL, 32'h44);
      expect_a("t6_unf_no_ovf_a", 8'({if_a.underflow, if_a.overflow}), 8'h02);
      expect_b("t6_unf_pc_b", if_b.pc_value, 12'h066);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_async_reset();
      test_increment();
      test_call_ret();
      test_stack_limits();
      test_jump_rel();
      test_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
